barrido_ctrl: RTL and testbench
===============================

# barrido_ctrl

Sweep sequencer for the combinational exercise blocks: on `start` it drives every input combination of an `N_IN`-input combinational unit in ascending binary order and waits a programmable settle time per vector. It samples the unit's outputs and compares them against an expected truth table, counting mismatches. It also streams every observed output word to a capture RAM. It sits between the combinational block under exercise, an expected-value ROM and the board-level status LEDs, and replaces exhaustive hand-written stimulus with a hardware-driven truth-table check.

## Interface
- `N_IN`, 6, number of combinational inputs; vector space is 2^N_IN.
- `N_OUT`, 2, number of combinational outputs.
- `SETTLE`, 1, idle cycles between applying a vector and sampling it (0 allowed).
- `clk  in  1  single system clock; all state changes on rising edge.`
- `rst_n  in  1  asynchronous, active-low reset.`
- `start  in  1  begin a sweep; honoured only in IDLE.`
- `abort  in  1  cancel a running sweep.`
- `vec_o  out  N_IN  input vector to the unit; MSB maps to input a, LSB to input f.`
- `dut_i  in  N_OUT  unit outputs; MSB is x, LSB is y.`
- `exp_i  in  N_OUT  expected outputs for vec_o, from a combinational ROM.`
- `cap_we  out  1  capture-RAM write strobe.`
- `cap_addr  out  N_IN  capture address, equal to vec_o.`
- `cap_data  out  N_OUT  equal to dut_i.`
- `busy  out  1  high outside IDLE and DONE.`
- `done  out  1  one-cycle pulse at sweep completion.`
- `pass  out  1  last completed sweep had zero mismatches.`
- `err_cnt  out  N_IN+1  mismatch count; saturation is not needed because the maximum is 2^N_IN.`

## Operation
- States are IDLE, SETTLE, SAMPLE and DONE.
- IDLE with `start`=1 and `abort`=0: clear `vec_o`, `err_cnt` and `pass` to 0, clear the settle counter, then go to SETTLE. If `SETTLE`=0, go straight to SAMPLE instead.
- SETTLE: increment the settle counter; on reaching `SETTLE`-1, go to SAMPLE.
- SAMPLE (exactly one cycle):
  - `cap_we`=1, decoded from state.
  - If `dut_i`≠`exp_i`, increment `err_cnt`.
  - If `vec_o`=2^N_IN−1, go to DONE. Otherwise increment `vec_o`, clear the settle counter and return to SETTLE (or stay in SAMPLE when `SETTLE`=0).
- DONE: `done`=1 for one cycle; `pass` is registered as (final `err_cnt`==0); then go to IDLE.
- `pass` and `err_cnt` hold until the next accepted `start`.
- `vec_o` holds its last value in IDLE.
- `abort` in SETTLE or SAMPLE: next state is IDLE.
  - No `done` pulse, `pass`=0, `err_cnt` keeps its partial value.
  - A mismatch sampled in that same SAMPLE cycle is not counted, and `cap_we` is suppressed.
- `start` while busy is ignored.
- `start` and `abort` together in IDLE: `abort` wins and the block stays in IDLE.
- `vec_o` never wraps during a sweep; the terminal vector ends the sweep.

## Timing
- Reset values: state IDLE, `vec_o`=0, `err_cnt`=0, `pass`=0, `done`=0, `busy`=0, `cap_we`=0.
- Reset asserted mid-sweep returns to these values immediately. No sweep resumes after reset.
- Per-vector period is `SETTLE`+1 cycles.
- `done` is high in the cycle beginning 2^N_IN·(`SETTLE`+1) rising edges after the edge that sampled `start`. For the defaults that is 128 edges.
- `busy` rises the cycle after `start` is sampled. It falls in the cycle where `done` is high, or the cycle after `abort` is sampled.
- Every sampled value comes from a vector that has been stable for ≥`SETTLE`+1 cycles.

## Configuration
- `BARRIDO_FIRST_FAIL_EN`, when defined:
  - Adds outputs `first_fail_vec` (N_IN bits) and `first_fail_vld` (1 bit).
  - On the first counted mismatch of a sweep, the current `vec_o` is latched and `first_fail_vld` is set.
  - Both clear on accepted `start` and on reset; both hold through DONE and abort.
- When not defined: these ports and their registers do not exist, and all other behaviour is identical.

## Structure
- `barrido_pkg` holds:
  - State encoding localparams: IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3.
  - Default widths: N_IN=6, N_OUT=2.
- Natural sub-module: `barrido_cmp`. It does the compare, `err_cnt` accumulation and first-fail latch, enabled by a sample strobe and cleared by a start strobe.
- FSM, vector counter and settle counter live in the top.

## Test plan
- Loopback with `dut_i`=`exp_i` and defaults, pulse `start` → `busy` next cycle, 64 `cap_we` pulses with `cap_addr` 0..63 in order, `done` 128 edges after start, `pass`=1, `err_cnt`=0.
- `dut_i` forced wrong only at vectors 0x2A and 0x3F → `err_cnt`=2, `pass`=0. With the macro defined: `first_fail_vec`=0x2A, `first_fail_vld`=1.
- `abort` while `vec_o`=10, in SETTLE → IDLE next cycle, no `done`, `pass`=0, at most 10 `cap_we` pulses seen.
- `start` re-pulsed during the sweep, plus `start` and `abort` together in IDLE → no restart, `vec_o` sequence uninterrupted, and the block stays idle for the simultaneous case.
- `rst_n` low at vector 30 → all outputs at reset values immediately. A later `start` sweeps from 0.
- `SETTLE`=0 and `SETTLE`=3 → `done` at 64 and 256 edges after start respectively, and `cap_we` spacing is 1 and 4 cycles respectively.

Source files
------------

// File: rtl/barrido_pkg.sv
// barrido_pkg: shared state encoding, default widths and helpers for the
// barrido truth-table sweep sequencer.
package barrido_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  localparam int N_IN_DEF   = 6;
  localparam int N_OUT_DEF  = 2;
  localparam int SETTLE_DEF = 1;

  // Settle counter only has to hold 0..SETTLE-1; keep at least one bit.
  function automatic int settle_cnt_w(input int settle);
    return (settle > 2) ? $clog2(settle) : 1;
  endfunction

endpackage

// File: rtl/barrido_cmp.sv
// barrido_cmp: output compare and mismatch accumulation for one sweep.
// First-fail capture is present only when BARRIDO_FIRST_FAIL_EN is defined.
module barrido_cmp
  import barrido_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             smp_i,
`ifdef BARRIDO_FIRST_FAIL_EN
  input  logic [N_IN-1:0]  vec_i,
`endif
  input  logic [N_OUT-1:0] dut_i,
  input  logic [N_OUT-1:0] exp_i,
  output logic [N_IN:0]    err_cnt_o
`ifdef BARRIDO_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]  ff_vec_o,
  output logic             ff_vld_o
`endif
);

  logic            miss;
  logic [N_IN:0]   err_q, err_d;

  assign miss = smp_i && (dut_i != exp_i);

  always_comb begin
    err_d = err_q;
    if (clr_i) begin
      err_d = '0;
    end else if (miss) begin
      err_d = err_q + (N_IN+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt_o = err_q;

`ifdef BARRIDO_FIRST_FAIL_EN
  logic [N_IN-1:0] ff_vec_q, ff_vec_d;
  logic            ff_vld_q, ff_vld_d;

  // Only the first counted miss latches; later misses leave it untouched.
  always_comb begin
    ff_vec_d = ff_vec_q;
    ff_vld_d = ff_vld_q;
    if (clr_i) begin
      ff_vec_d = '0;
      ff_vld_d = 1'b0;
    end else if (miss && !ff_vld_q) begin
      ff_vec_d = vec_i;
      ff_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_vec_q <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      ff_vec_q <= ff_vec_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  assign ff_vec_o = ff_vec_q;
  assign ff_vld_o = ff_vld_q;
`endif

endmodule

// File: rtl/barrido_ctrl.sv
// barrido_ctrl: drives every input vector of a combinational unit in order,
// samples after a settle time and counts mismatches. BARRIDO_FIRST_FAIL_EN adds first-fail capture.
module barrido_ctrl
  import barrido_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  vec_o,
  input  logic [N_OUT-1:0] dut_i,
  input  logic [N_OUT-1:0] exp_i,
  output logic             cap_we,
  output logic [N_IN-1:0]  cap_addr,
  output logic [N_OUT-1:0] cap_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
`ifdef BARRIDO_FIRST_FAIL_EN
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_vld,
`endif
  output logic [N_IN:0]    err_cnt
);

  localparam int               CNT_W       = settle_cnt_w(SETTLE);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N_IN-1:0]  VEC_LAST    = '1;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] set_cnt_q, set_cnt_d;
  logic             pass_q, pass_d;
  logic             start_acc, smp, adv, settle_end;

  assign settle_end = (set_cnt_q == SETTLE_LAST);
  assign adv        = smp && (vec_q != VEC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (settle_end) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (vec_q == VEC_LAST) begin
          state_d = ST_DONE;
        end else if (SETTLE != 0) begin
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // An abort in SAMPLE kills both the capture strobe and the compare.
  always_comb begin
    start_acc = 1'b0;
    smp       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE:   start_acc = start && !abort;
      ST_SETTLE: busy = 1'b1;
      ST_SAMPLE: begin
        busy = 1'b1;
        smp  = !abort;
      end
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  always_comb begin
    vec_d     = vec_q;
    set_cnt_d = set_cnt_q;
    pass_d    = pass_q;
    if (start_acc) begin
      vec_d     = '0;
      set_cnt_d = '0;
      pass_d    = 1'b0;
    end else if (adv) begin
      vec_d     = vec_q + N_IN'(1);
      set_cnt_d = '0;
    end else if (state_q == ST_SETTLE && !abort && !settle_end) begin
      set_cnt_d = set_cnt_q + CNT_W'(1);
    end else if (state_q == ST_DONE) begin
      pass_d = (err_cnt == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      set_cnt_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      vec_q     <= vec_d;
      set_cnt_q <= set_cnt_d;
      pass_q    <= pass_d;
    end
  end

  assign vec_o    = vec_q;
  assign cap_we   = smp;
  assign cap_addr = vec_q;
  assign cap_data = dut_i;
  assign pass     = pass_q;

  barrido_cmp #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_cmp (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (start_acc),
    .smp_i     (smp),
`ifdef BARRIDO_FIRST_FAIL_EN
    .vec_i     (vec_q),
`endif
    .dut_i     (dut_i),
    .exp_i     (exp_i),
    .err_cnt_o (err_cnt)
`ifdef BARRIDO_FIRST_FAIL_EN
    ,
    .ff_vec_o  (first_fail_vec),
    .ff_vld_o  (first_fail_vld)
`endif
  );

endmodule

// File: tb/tb_barrido_ctrl.sv
// tb_barrido_ctrl: randomized sweeps against a queue-based reference model of barrido_ctrl.
`timescale 1ns/1ps
module tb_barrido_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, start_b, abort_b;

  logic [5:0] vec_a, cap_addr_a;
  logic [1:0] dut_a, exp_a, cap_data_a;
  logic       cap_we_a, busy_a, done_a, pass_a;
  logic [6:0] err_a;

  logic [5:0] vec_s0, cap_addr_s0, vec_s3, cap_addr_s3;
  logic [1:0] dut_s0, exp_s0, cap_data_s0, dut_s3, exp_s3, cap_data_s3;
  logic       cap_we_s0, busy_s0, done_s0, pass_s0;
  logic       cap_we_s3, busy_s3, done_s3, pass_s3;
  logic [6:0] err_s0, err_s3;

`ifdef BARRIDO_FIRST_FAIL_EN
  logic [5:0] ffv_a, ffv_s0, ffv_s3;
  logic       ffl_a, ffl_s0, ffl_s3;
`endif

  // Combinational unit model: expected table plus an injected error mask.
  logic [1:0] rom  [64];
  logic [1:0] flip [64];

  assign exp_a  = rom[vec_a];
  assign dut_a  = rom[vec_a] ^ flip[vec_a];
  assign exp_s0 = rom[vec_s0];
  assign dut_s0 = rom[vec_s0];
  assign exp_s3 = rom[vec_s3];
  assign dut_s3 = rom[vec_s3];

  barrido_ctrl #(.N_IN(6), .N_OUT(2), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .vec_o(vec_a),
    .dut_i(dut_a), .exp_i(exp_a), .cap_we(cap_we_a), .cap_addr(cap_addr_a),
    .cap_data(cap_data_a), .busy(busy_a), .done(done_a), .pass(pass_a),
`ifdef BARRIDO_FIRST_FAIL_EN
    .first_fail_vec(ffv_a), .first_fail_vld(ffl_a),
`endif
    .err_cnt(err_a)
  );

  barrido_ctrl #(.N_IN(6), .N_OUT(2), .SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .vec_o(vec_s0),
    .dut_i(dut_s0), .exp_i(exp_s0), .cap_we(cap_we_s0), .cap_addr(cap_addr_s0),
    .cap_data(cap_data_s0), .busy(busy_s0), .done(done_s0), .pass(pass_s0),
`ifdef BARRIDO_FIRST_FAIL_EN
    .first_fail_vec(ffv_s0), .first_fail_vld(ffl_s0),
`endif
    .err_cnt(err_s0)
  );

  barrido_ctrl #(.N_IN(6), .N_OUT(2), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .vec_o(vec_s3),
    .dut_i(dut_s3), .exp_i(exp_s3), .cap_we(cap_we_s3), .cap_addr(cap_addr_s3),
    .cap_data(cap_data_s3), .busy(busy_s3), .done(done_s3), .pass(pass_s3),
`ifdef BARRIDO_FIRST_FAIL_EN
    .first_fail_vec(ffv_s3), .first_fail_vld(ffl_s3),
`endif
    .err_cnt(err_s3)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  typedef struct packed {
    logic [5:0] addr;
    logic [1:0] data;
  } cap_t;

  typedef struct {
    int cyc;
    int err;
    int pass;
  } done_t;

  cap_t  cap_q[$];
  done_t done_q[$];
  bit    pass_pend = 1'b0;
  int    pass_exp  = 0;

  always @(negedge clk) begin : mon
    cap_t  c;
    done_t d;
    if (rst_n === 1'b1) begin
      if (pass_pend) begin
        chk("pass_after_done", pass_a, pass_exp);
        pass_pend = 1'b0;
      end
      if (cap_we_a) begin
        if (cap_q.size() == 0) begin
          fail_now("unexpected_cap_we");
        end else begin
          c = cap_q.pop_front();
          chk("cap_addr", cap_addr_a, c.addr);
          chk("cap_data", cap_data_a, c.data);
        end
      end
      if (done_a) begin
        if (done_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          chk("err_cnt_at_done", err_a, d.err);
          pass_exp  = d.pass;
          pass_pend = 1'b1;
        end
      end
    end
  end

  int cnt_s0 = 0, last_s0 = 0, done_s0c = -1;
  int cnt_s3 = 0, last_s3 = 0, done_s3c = -1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cap_we_s0) begin
        if (cnt_s0 > 0) chk("s0_cap_spacing", cyc - last_s0, 1);
        chk("s0_cap_addr", cap_addr_s0, cnt_s0);
        last_s0 = cyc;
        cnt_s0++;
      end
      if (cap_we_s3) begin
        if (cnt_s3 > 0) chk("s3_cap_spacing", cyc - last_s3, 4);
        chk("s3_cap_addr", cap_addr_s3, cnt_s3);
        last_s3 = cyc;
        cnt_s3++;
      end
      if (done_s0) done_s0c = cyc;
      if (done_s3) done_s3c = cyc;
    end
  end

  // mode 0: loopback, 1: faults only at 0x2A and 0x3F, 2: sparse random faults
  task automatic set_tables(input int mode);
    for (int v = 0; v < 64; v++) begin
      rom[v] = 2'($urandom_range(0, 3));
      case (mode)
        1:       flip[v] = (v == 42 || v == 63) ? 2'b01 : 2'b00;
        2:       flip[v] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        default: flip[v] = 2'b00;
      endcase
    end
  endtask

  // kind 0: full sweep, 1: abort in SETTLE of sv, 2: abort in SAMPLE of sv, 3: reset in SETTLE of sv
  task automatic run_sweep(input int kind, input int sv, input bit rep);
    int   s, nerr, ff, ncap, x;
    cap_t  c;
    done_t d;
    ncap = (kind == 0) ? 64 : sv;
    nerr = 0;
    ff   = -1;
    for (int v = 0; v < ncap; v++) begin
      c.addr = 6'(v);
      c.data = rom[v] ^ flip[v];
      cap_q.push_back(c);
      if (flip[v] != 2'b00) begin
        nerr++;
        if (ff < 0) ff = v;
      end
    end
    @(negedge clk);
    start = 1'b1;
    s = cyc + 1;
    if (kind == 0) begin
      d.cyc  = s + 128;
      d.err  = nerr;
      d.pass = (nerr == 0) ? 1 : 0;
      done_q.push_back(d);
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);
    chk("vec_cleared", vec_a, 0);
    chk("err_cleared", err_a, 0);
    if (kind == 0) begin
      for (int i = 0; i < 300 && busy_a; i++) begin
        start = rep && (i == 20 || i == 77);
        @(negedge clk);
      end
      start = 1'b0;
      chk("sweep_ends", busy_a, 0);
      repeat (3) @(negedge clk);
      chk("err_cnt_hold", err_a, nerr);
      chk("pass_hold", pass_a, (nerr == 0) ? 1 : 0);
      chk("vec_hold_idle", vec_a, 63);
    end else begin
      x = s + 2 * sv + ((kind == 2) ? 1 : 0);
      while (cyc < x) @(negedge clk);
      chk("vec_at_stop", vec_a, sv);
      if (kind == 3) begin
        rst_n = 1'b0;
        #1;
        chk("rst_vec", vec_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_cap_we", cap_we_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_pass", pass_a, 0);
`ifdef BARRIDO_FIRST_FAIL_EN
        chk("rst_ff_vld", ffl_a, 0);
        chk("rst_ff_vec", ffv_a, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_vec_hold", vec_a, sv);
        chk("abort_err", err_a, nerr);
        chk("abort_pass", pass_a, 0);
      end
      repeat (4) @(negedge clk);
      chk("stopped_idle", busy_a, 0);
    end
`ifdef BARRIDO_FIRST_FAIL_EN
    if (kind != 3) begin
      chk("ff_vld", ffl_a, (ff >= 0) ? 1 : 0);
      if (ff >= 0) chk("ff_vec", ffv_a, ff);
    end
`endif
    chk("caps_left", cap_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e_prev;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    start_b = 1'b0;
    abort_b = 1'b0;
    set_tables(0);
    repeat (3) @(negedge clk);
    chk("reset_vec", vec_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_cap_we", cap_we_a, 0);
    chk("reset_err", err_a, 0);
    chk("reset_pass", pass_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    set_tables(0);
    run_sweep(0, 0, 1'b0);

    set_tables(1);
    run_sweep(0, 0, 1'b0);

    set_tables(2);
    run_sweep(0, 0, 1'b1);

    // start and abort together in IDLE: nothing may happen
    e_prev = err_a;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    chk("start_abort_idle_err", err_a, e_prev);
    chk("start_abort_idle_vec", vec_a, 63);

    set_tables(2);
    run_sweep(1, 10, 1'b0);

    set_tables(2);
    flip[5] = 2'b10;
    run_sweep(2, 5, 1'b0);

    set_tables(2);
    run_sweep(3, 30, 1'b0);
    set_tables(2);
    run_sweep(0, 0, 1'b0);

    set_tables(0);
    cnt_s0   = 0;
    cnt_s3   = 0;
    done_s0c = -1;
    done_s3c = -1;
    @(negedge clk);
    start_b = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start_b = 1'b0;
    chk("s0_busy_after_start", busy_s0, 1);
    chk("s3_busy_after_start", busy_s3, 1);
    for (int i = 0; i < 400 && done_s3c < 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("s0_done_cycle", done_s0c, s + 64);
    chk("s3_done_cycle", done_s3c, s + 256);
    chk("s0_cap_count", cnt_s0, 64);
    chk("s3_cap_count", cnt_s3, 64);
    chk("s0_pass", pass_s0, 1);
    chk("s3_pass", pass_s3, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
